// File: rtl/mem_responder.sv
// Single-port memory responder: zero-fill sweep after reset, one-cycle read
// latency, sticky collision error, per-location written tracking and
// saturating request counters.
module mem_responder #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              err,
   output logic              uninit,
   output logic [15:0]       wr_count,
   output logic [15:0]       rd_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
   logic [DEPTH-1:0]    written_q, written_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic                rd_valid_q, rd_valid_d;
   logic                uninit_q, uninit_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [15:0]         wr_count_q, wr_count_d;
   logic [15:0]         rd_count_q, rd_count_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   // Next-state logic: init sweep, request decode and output updates
   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      written_d   = written_q;
      data_out_d  = data_out_q;
      rd_valid_d  = 1'b0;
      uninit_d    = 1'b0;
      busy_d      = busy_q;
      err_d       = err_q;
      wr_count_d  = wr_count_q;
      rd_count_d  = rd_count_q;
      mem_we      = 1'b0;
      mem_waddr   = addr;
      mem_wdata   = data_in;

      case (state_q)
         INIT: begin
            mem_we      = 1'b1;
            mem_waddr   = init_addr_q;
            mem_wdata   = '0;
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == '1) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         IDLE, RESP: begin
            // RESP accepts requests exactly like IDLE; a fresh read keeps
            // rd_valid high for back-to-back responses.
            state_d = IDLE;
            if (read && write) begin
               err_d = 1'b1;
            end else if (write) begin
               mem_we          = 1'b1;
               written_d[addr] = 1'b1;
               if (wr_count_q != '1) wr_count_d = wr_count_q + 16'd1;
            end else if (read) begin
               data_out_d = mem[addr];
               rd_valid_d = 1'b1;
               uninit_d   = ~written_q[addr];
               state_d    = RESP;
               if (rd_count_q != '1) rd_count_d = rd_count_q + 16'd1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // Control and output registers, asynchronously forced back to INIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         written_q   <= '0;
         data_out_q  <= '0;
         rd_valid_q  <= 1'b0;
         uninit_q    <= 1'b0;
         busy_q      <= 1'b1;
         err_q       <= 1'b0;
         wr_count_q  <= '0;
         rd_count_q  <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         written_q   <= written_d;
         data_out_q  <= data_out_d;
         rd_valid_q  <= rd_valid_d;
         uninit_q    <= uninit_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
      end
   end

   // Storage array; contents are cleared by the init sweep, not by reset
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign data_out = data_out_q;
   assign rd_valid = rd_valid_q;
   assign uninit   = uninit_q;
   assign busy     = busy_q;
   assign err      = err_q;
   assign wr_count = wr_count_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus hand-written sequences
// for the init sweep, mid-response reset and counter saturation.
module tb_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        read;
   logic        write;
   logic [4:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        rd_valid;
   logic        busy;
   logic        err;
   logic        uninit;
   logic [15:0] wr_count;
   logic [15:0] rd_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [4:0] a;
      logic [7:0] d;
      logic       ev;
      logic [7:0] edout;
      logic       eu;
      logic       eerr;
   } vec_t;

   vec_t vecs[$];

   mem_responder #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .read     (read),
      .write    (write),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .rd_valid (rd_valid),
      .busy     (busy),
      .err      (err),
      .uninit   (uninit),
      .wr_count (wr_count),
      .rd_count (rd_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Count edges with busy high, starting at a negedge just after reset release.
   // Inputs are cycled through read/write/both to confirm they are ignored.
   task automatic count_busy(output int n);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (!busy) break;
         read  = n[0];
         write = n[1];
         addr  = 5'(n);
      end
      read  = 1'b0;
      write = 1'b0;
   endtask

   function automatic vec_t mk(input logic rd, input logic wr, input logic [4:0] a,
                               input logic [7:0] d, input logic ev, input logic [7:0] edout,
                               input logic eu, input logic eerr);
      vec_t v;
      v.rd = rd; v.wr = wr; v.a = a; v.d = d;
      v.ev = ev; v.edout = edout; v.eu = eu; v.eerr = eerr;
      return v;
   endfunction

   initial begin
      int n;

      // Table: write data=address everywhere, read it all back, then
      // overwrite/read-order and collision cases.
      for (int i = 0; i < 32; i++) vecs.push_back(mk(0, 1, 5'(i), 8'(i), 0, 8'h00, 0, 0));
      for (int i = 0; i < 32; i++) vecs.push_back(mk(1, 0, 5'(i), 8'h00, 1, 8'(i), 0, 0));
      vecs.push_back(mk(0, 1, 5'd3, 8'hA5, 0, 8'h1F, 0, 0));
      vecs.push_back(mk(1, 0, 5'd3, 8'h00, 1, 8'hA5, 0, 0));
      vecs.push_back(mk(1, 0, 5'd4, 8'h00, 1, 8'h04, 0, 0));
      vecs.push_back(mk(0, 0, 5'd0, 8'h00, 0, 8'h04, 0, 0));
      vecs.push_back(mk(1, 0, 5'd5, 8'h00, 1, 8'h05, 0, 0));
      vecs.push_back(mk(0, 1, 5'd5, 8'h55, 0, 8'h05, 0, 0));
      vecs.push_back(mk(1, 0, 5'd5, 8'h00, 1, 8'h55, 0, 0));
      vecs.push_back(mk(1, 1, 5'd7, 8'hFF, 0, 8'h55, 0, 1));
      vecs.push_back(mk(0, 0, 5'd0, 8'h00, 0, 8'h55, 0, 1));
      vecs.push_back(mk(1, 0, 5'd7, 8'h00, 1, 8'h07, 0, 1));
      vecs.push_back(mk(0, 0, 5'd0, 8'h00, 0, 8'h07, 0, 1));

      rst_n = 1'b0; read = 1'b1; write = 1'b1; addr = 5'd7; data_in = 8'hFF;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_uninit", 32'(uninit), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      chk("rst_wrcnt", 32'(wr_count), 32'd0);
      chk("rst_rdcnt", 32'(rd_count), 32'd0);

      // Init sweep length with requests hammering throughout
      rst_n = 1'b1;
      count_busy(n);
      chk("sweep_len", 32'(n), 32'd32);
      chk("sweep_err", 32'(err), 32'd0);
      chk("sweep_wrcnt", 32'(wr_count), 32'd0);
      chk("sweep_rdcnt", 32'(rd_count), 32'd0);
      chk("sweep_valid", 32'(rd_valid), 32'd0);

      // Back-to-back reads of every location after the sweep
      for (int i = 0; i < 32; i++) begin
         read = 1'b1; addr = 5'(i);
         @(posedge clk); @(negedge clk);
         chk($sformatf("zero_valid[%0d]", i), 32'(rd_valid), 32'd1);
         chk($sformatf("zero_dout[%0d]", i), 32'(data_out), 32'd0);
         chk($sformatf("zero_uninit[%0d]", i), 32'(uninit), 32'd1);
      end
      read = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("zero_valid_drop", 32'(rd_valid), 32'd0);
      chk("zero_rdcnt", 32'(rd_count), 32'd32);

      // Vector table
      foreach (vecs[i]) begin
         read = vecs[i].rd; write = vecs[i].wr; addr = vecs[i].a; data_in = vecs[i].d;
         @(posedge clk); @(negedge clk);
         chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
         chk($sformatf("v%0d_dout", i), 32'(data_out), 32'(vecs[i].edout));
         chk($sformatf("v%0d_uninit", i), 32'(uninit), 32'(vecs[i].eu));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].eerr));
      end
      read = 1'b0; write = 1'b0;
      chk("tbl_wrcnt", 32'(wr_count), 32'd34);
      chk("tbl_rdcnt", 32'(rd_count), 32'd69);

      // Reset pulsed while a response is being presented
      read = 1'b1; addr = 5'd9;
      @(posedge clk);
      #2 read = 1'b0;
      chk("resp_valid", 32'(rd_valid), 32'd1);
      chk("resp_dout", 32'(data_out), 32'd9);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_wrcnt", 32'(wr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_busy(n);
      chk("resweep_len", 32'(n), 32'd32);
      read = 1'b1; addr = 5'd3;
      @(posedge clk); @(negedge clk);
      read = 1'b0;
      chk("resweep_dout", 32'(data_out), 32'd0);
      chk("resweep_uninit", 32'(uninit), 32'd1);
      chk("resweep_rdcnt", 32'(rd_count), 32'd1);

      // Write counter saturation
      write = 1'b1; addr = 5'd1; data_in = 8'h11;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      write = 1'b0;
      chk("sat_pre", 32'(wr_count), 32'h0000FFFE);
      write = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      write = 1'b0;
      chk("sat_hold", 32'(wr_count), 32'h0000FFFF);
      chk("sat_rdcnt", 32'(rd_count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning address width; depth is 2**ADDR_W (32).
REQ-002 SHALL have parameter DATA_W, default 8, meaning data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low; deassertion is sampled on clk.
REQ-005 SHALL have port read  input  1  read request strobe, one cycle per request.
REQ-006 SHALL have port write  input  1  write request strobe, one cycle per request.
REQ-007 SHALL have port addr  input  ADDR_W  request address.
REQ-008 SHALL have port data_in  input  DATA_W  write data.
REQ-009 SHALL have port data_out  output  DATA_W  registered read data.
REQ-010 SHALL have port rd_valid  output  1  one-cycle pulse, data_out valid.
REQ-011 SHALL have port busy  output  1  high during the init sweep; requests ignored.
REQ-012 SHALL have port err  output  1  sticky, set on read and write in the same cycle.
REQ-013 SHALL have port uninit  output  1  one-cycle pulse with rd_valid when the read location has not been written since reset.
REQ-014 SHALL have port wr_count  output  16  saturating count of accepted writes.
REQ-015 SHALL have port rd_count  output  16  saturating count of accepted reads.

Function
REQ-016 SHALL implement FSM states INIT, IDLE and RESP.
REQ-017 SHALL, in INIT, write 0 to one location per cycle, addresses 0 to depth-1 ascending, with busy=1; after location depth-1 it SHALL move to IDLE, so busy is high for exactly 32 cycles after reset release.
REQ-018 SHALL ignore read and write while busy=1: no storage change, no counter change, no rd_valid, no err.
REQ-019 SHALL, in IDLE, with write=1 and read=0, store data_in at addr on that edge, set written[addr], increment wr_count, and stay in IDLE.
REQ-020 SHALL, in IDLE, with read=1 and write=0, capture mem[addr] into data_out, go to RESP, and increment rd_count.
REQ-021 SHALL, in RESP, drive rd_valid=1 for one cycle, with uninit=1 if written[addr] was 0 when the request was sampled, then return to IDLE; read latency is 1 cycle, request edge to rd_valid.
REQ-022 SHALL accept a new request in the RESP cycle exactly as in IDLE, which allows back-to-back reads every cycle with rd_valid held continuously.
REQ-023 SHALL treat read=1 and write=1 together as a no-op on storage, counters and data_out, and SHALL set err, which holds until reset.
REQ-024 SHALL hold data_out at its last read value when rd_valid=0.
REQ-025 SHALL saturate wr_count and rd_count at 16'hFFFF, with no wrap.
REQ-026 SHALL take the address as exactly ADDR_W bits; every address value is in range, with no wrap logic.
REQ-027 SHALL perform a write issued the cycle after a read to the same address after that read's capture, so the read returns the old data.

Reset
REQ-028 SHALL, on rst_n low, asynchronously force: state=INIT, busy=1, data_out=0, rd_valid=0, uninit=0, err=0, wr_count=0, rd_count=0, and all written bits=0.
REQ-029 SHALL, on reset mid-operation (during INIT, RESP or a write), abort that operation; it SHALL restart the full INIT sweep after release and drop any pending rd_valid.
REQ-030 SHALL NOT require storage contents to be reset asynchronously; the INIT sweep guarantees every location reads 0 once busy falls.

Verification
REQ-031 SHALL cover: release reset, then count cycles with busy=1 -> exactly 32; then read addresses 0..31 -> each data_out=8'h00 with uninit=1, and rd_count=32.
REQ-032 SHALL cover: write data=address at addresses 0..31, then read back -> data_out equals address each time, uninit=0, and wr_count=32.
REQ-033 SHALL cover: write 8'hA5 to address 3, then read 3 on consecutive cycles with back-to-back reads of 3 and 4 -> rd_valid high 2 cycles, with data 8'hA5 then 8'h04 or 8'h00 per prior state.
REQ-034 SHALL cover: read=1 and write=1 at address 7 with data 8'hFF -> err=1 and stays high, mem[7] unchanged, and both counters unchanged.
REQ-035 SHALL cover: requests during busy -> ignored, with counters still 0 after INIT; and rst_n pulsed low mid-RESP -> rd_valid=0 immediately, busy=1, and a full 32-cycle sweep.
REQ-036 SHALL cover: 65 540 writes -> wr_count=16'hFFFF with no wrap.
